rast_span_emitter: RTL and testbench

Upstream stage of the framebuffer writer. It accepts horizontal span commands (line, start column, end column, colour) and clear requests from the rasterizer core. It expands each span into one 96-bit pixel word per column and pushes the words into the rasterizer→fbwriter FIFO. A clear request becomes the single all-ones flush word that the framebuffer writer interprets as a full-screen clear.

---
 rtl/rast_span_emitter.sv | 130 +++++++++++++
 tb/tb_rast_span_emitter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rast_span_emitter.sv
// Expands horizontal span commands into one 96-bit pixel word per column for the fbwriter FIFO,
// and turns clear requests into the all-ones flush word. Optional clipping: RAST_SPAN_CLIP_EN.
module rast_span_emitter #(
    parameter int unsigned RAST_FBW_FIFO_LEN = 96,
    parameter int unsigned LINE_LEN          = 9,
    parameter int unsigned COL_LEN           = 10,
    parameter int unsigned LINES             = 480,
    parameter int unsigned COLS              = 640
) (
    input  logic                           PLB_clk,
    input  logic                           reset,
    input  logic                           span_valid,
    output logic                           span_ready,
    input  logic [LINE_LEN:0]              span_line,
    input  logic [COL_LEN:0]               span_x0,
    input  logic [COL_LEN:0]               span_x1,
    input  logic [31:0]                    span_color,
    input  logic                           clear_req,
    output logic                           clear_ack,
    input  logic                           fifo_full,
    output logic                           fifo_wr_en,
    output logic [0:RAST_FBW_FIFO_LEN-1]   fifo_din,
    output logic                           busy
);

    typedef enum logic [1:0] {StIdle, StSpan, StClear} state_e;

    localparam logic [COL_LEN:0] XOne = 1;

    state_e                        state_q, state_d;
    logic   [LINE_LEN:0]           line_q, line_d;
    logic   [31:0]                 color_q, color_d;
    logic   [COL_LEN:0]            cur_x_q, cur_x_d;
    logic   [COL_LEN:0]            x_end_q, x_end_d;

    logic   [COL_LEN:0]            x_lo, x_hi, x_end_new;
    logic                          span_drop;
    logic   [0:RAST_FBW_FIFO_LEN-1] pix_word;
    logic                          unused_line_msb;

    // Only the low LINE_LEN bits reach the FIFO word; with clipping they already fit.
    assign unused_line_msb = line_q[LINE_LEN];

    assign x_lo = (span_x0 < span_x1) ? span_x0 : span_x1;
    assign x_hi = (span_x0 < span_x1) ? span_x1 : span_x0;

`ifdef RAST_SPAN_CLIP_EN
    localparam logic [LINE_LEN:0] LinesLim = LINES[LINE_LEN:0];
    localparam logic [COL_LEN:0]  ColsLim  = COLS[COL_LEN:0];
    localparam int unsigned       ColsM1   = COLS - 1;
    localparam logic [COL_LEN:0]  ColsMax  = ColsM1[COL_LEN:0];

    assign span_drop = (span_line >= LinesLim) || (x_lo >= ColsLim);
    assign x_end_new = (x_hi > ColsMax) ? ColsMax : x_hi;
`else
    logic unused_clip_params;

    assign unused_clip_params = ^{LINES, COLS};
    assign span_drop          = 1'b0;
    assign x_end_new          = x_hi;
`endif

    always_comb begin
        pix_word        = '0;
        pix_word[0:15]  = {{(16 - LINE_LEN){1'b0}}, line_q[LINE_LEN-1:0]};
        pix_word[16:31] = {{(16 - COL_LEN){1'b0}}, cur_x_q[COL_LEN-1:0]};
        pix_word[32:63] = color_q;
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        color_d    = color_q;
        cur_x_d    = cur_x_q;
        x_end_d    = x_end_q;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        clear_ack  = 1'b0;
        span_ready = (state_q == StIdle);
        busy       = (state_q != StIdle);
        case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d = StClear;
                end else if (span_valid) begin
                    line_d  = span_line;
                    color_d = span_color;
                    cur_x_d = x_lo;
                    x_end_d = x_end_new;
                    // A dropped span is still consumed; the block simply stays idle.
                    if (!span_drop) state_d = StSpan;
                end
            end
            StSpan: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = pix_word;
                if (!fifo_full) begin
                    cur_x_d = cur_x_q + XOne;
                    if (cur_x_q == x_end_q) state_d = StIdle;
                end
            end
            StClear: begin
                fifo_wr_en = !fifo_full;
                fifo_din   = '1;
                if (!fifo_full) begin
                    clear_ack = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            state_q <= StIdle;
            line_q  <= '0;
            color_q <= '0;
            cur_x_q <= '0;
            x_end_q <= '0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            color_q <= color_d;
            cur_x_q <= cur_x_d;
            x_end_q <= x_end_d;
        end
    end

endmodule

// File: tb/tb_rast_span_emitter.sv
// Randomized bench for rast_span_emitter: a queue of expected FIFO words, built per command from
// plain column arithmetic, is compared against every observed write.
module tb_rast_span_emitter;

    logic        PLB_clk = 1'b0;
    logic        reset = 1'b1;
    logic        span_valid = 1'b0;
    logic        span_ready;
    logic [9:0]  span_line = '0;
    logic [10:0] span_x0 = '0;
    logic [10:0] span_x1 = '0;
    logic [31:0] span_color = '0;
    logic        clear_req = 1'b0;
    logic        clear_ack;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [0:95] fifo_din;
    logic        busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [95:0] exp_q[$];
    logic        bp_en = 1'b0;

    rast_span_emitter dut (
        .PLB_clk    (PLB_clk),
        .reset      (reset),
        .span_valid (span_valid),
        .span_ready (span_ready),
        .span_line  (span_line),
        .span_x0    (span_x0),
        .span_x1    (span_x1),
        .span_color (span_color),
        .clear_req  (clear_req),
        .clear_ack  (clear_ack),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .busy       (busy)
    );

    always #5 PLB_clk = ~PLB_clk;

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk_word(input int l, input int c, input logic [31:0] col);
        return {l[15:0], c[15:0], col, 32'h0};
    endfunction

    // Reference: every column from the smaller to the larger endpoint, in ascending order.
    task automatic model_span(input int line, input int x0, input int x1, input logic [31:0] col);
        int lo = (x0 < x1) ? x0 : x1;
        int hi = (x0 < x1) ? x1 : x0;
`ifdef RAST_SPAN_CLIP_EN
        if (line >= 480 || lo >= 640) return;
        if (hi > 639) hi = 639;
`endif
        for (int c = lo; c <= hi; c++) exp_q.push_back(mk_word(line % 512, c % 1024, col));
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic do_span(input int line, input int x0, input int x1, input logic [31:0] col);
        int t = 0;
        span_line  = line[9:0];
        span_x0    = x0[10:0];
        span_x1    = x1[10:0];
        span_color = col;
        span_valid = 1'b1;
        @(negedge PLB_clk);
        while (!(span_ready && !clear_req) && t < 6000) begin
            t++;
            @(negedge PLB_clk);
        end
        if (t >= 6000) chk("span_accept_timeout", {95'b0, span_ready}, 96'd1);
        model_span(line, x0, x1, col);
        @(posedge PLB_clk);
        #1;
        span_valid = 1'b0;
    endtask

    task automatic do_clear();
        int t = 0;
        clear_req = 1'b1;
        exp_q.push_back('1);
        @(negedge PLB_clk);
        while (!clear_ack && t < 6000) begin
            t++;
            @(negedge PLB_clk);
        end
        if (t >= 6000) chk("clear_ack_timeout", {95'b0, clear_ack}, 96'd1);
        @(posedge PLB_clk);
        #1;
        clear_req = 1'b0;
    endtask

    // Expects n writes on consecutive cycles, then span_ready with no write.
    task automatic span_timing(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge PLB_clk);
            chk("span_write_cycle", {95'b0, fifo_wr_en}, 96'd1);
        end
        @(negedge PLB_clk);
        chk("ready_after_span", {95'b0, span_ready}, 96'd1);
        chk("no_write_after_span", {95'b0, fifo_wr_en}, 96'd0);
        @(posedge PLB_clk);
        #1;
    endtask

    always @(negedge PLB_clk) begin
        if (!reset) begin
            if (fifo_wr_en) begin
                if (exp_q.size() == 0) begin
                    chk("write_with_nothing_expected", {95'b0, fifo_wr_en}, 96'd0);
                end else begin
                    logic [95:0] w;
                    w = exp_q.pop_front();
                    chk("fifo_word", fifo_din, w);
                    chk("clear_ack_on_write", {95'b0, clear_ack}, {95'b0, (w == '1)});
                end
            end else begin
                chk("clear_ack_without_write", {95'b0, clear_ack}, 96'd0);
            end
            if (fifo_full) chk("write_under_full", {95'b0, fifo_wr_en}, 96'd0);
        end
    end

    always begin
        @(posedge PLB_clk);
        #1;
        if (bp_en) fifo_full = ($urandom_range(0, 3) == 0);
    end

    initial begin
        int t;
        repeat (2) @(posedge PLB_clk);
        #1;
        reset = 1'b0;
        @(negedge PLB_clk);
        chk("reset_span_ready", {95'b0, span_ready}, 96'd1);
        chk("reset_busy", {95'b0, busy}, 96'd0);
        chk("reset_fifo_wr_en", {95'b0, fifo_wr_en}, 96'd0);
        chk("reset_fifo_din", fifo_din, 96'd0);
        chk("reset_clear_ack", {95'b0, clear_ack}, 96'd0);
        @(posedge PLB_clk);
        #1;

        do_span(5, 10, 13, 32'h00FF00FF);
        span_timing(4);
        do_span(5, 13, 10, 32'h00FF00FF);
        span_timing(4);
        do_span(9, 0, 0, 32'hCAFEF00D);
        span_timing(1);

        // Backpressure for three cycles after the second pixel.
        do_span(5, 10, 13, 32'h12345678);
        repeat (2) begin
            @(negedge PLB_clk);
            chk("bp_write_before_stall", {95'b0, fifo_wr_en}, 96'd1);
        end
        @(posedge PLB_clk);
        #1;
        fifo_full = 1'b1;
        repeat (3) begin
            @(negedge PLB_clk);
            chk("bp_stalled", {95'b0, fifo_wr_en}, 96'd0);
            @(posedge PLB_clk);
            #1;
        end
        fifo_full = 1'b0;
        span_timing(2);

`ifdef RAST_SPAN_CLIP_EN
        do_span(480, 3, 20, 32'hDEADBEEF);
        repeat (4) begin
            @(negedge PLB_clk);
            chk("drop_ready", {95'b0, span_ready}, 96'd1);
            chk("drop_no_write", {95'b0, fifo_wr_en}, 96'd0);
        end
        @(posedge PLB_clk);
        #1;
        do_span(2, 630, 700, 32'h0BADCAFE);
        span_timing(10);
`endif

        // Clear and span together: flush goes first, span is taken afterwards.
        span_line  = 10'd3;
        span_x0    = 11'd40;
        span_x1    = 11'd42;
        span_color = 32'hA5A5A5A5;
        span_valid = 1'b1;
        do_clear();
        do_span(3, 40, 42, 32'hA5A5A5A5);
        span_timing(3);

        // Reset in the middle of a span abandons it.
        do_span(7, 0, 100, 32'h77777777);
        repeat (5) @(negedge PLB_clk);
        @(posedge PLB_clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(posedge PLB_clk);
        #1;
        reset = 1'b0;
        @(negedge PLB_clk);
        chk("post_reset_wr_en", {95'b0, fifo_wr_en}, 96'd0);
        chk("post_reset_busy", {95'b0, busy}, 96'd0);
        @(posedge PLB_clk);
        #1;

        bp_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 6) == 0) begin
                do_clear();
            end else begin
                int x0 = $urandom_range(0, 2047);
                int x1;
                if ($urandom_range(0, 3) == 0) x1 = $urandom_range(0, 2047);
                else begin
                    x1 = x0 + $urandom_range(0, 40) - 20;
                    if (x1 < 0) x1 = 0;
                    if (x1 > 2047) x1 = 2047;
                end
                do_span($urandom_range(0, 1023), x0, x1, $urandom);
            end
        end

        t = 0;
        while ((busy || exp_q.size() != 0) && t < 10000) begin
            t++;
            @(negedge PLB_clk);
        end
        bp_en = 1'b0;
        chk("pending_words", 96'(exp_q.size()), 96'd0);
        chk("busy_at_end", {95'b0, busy}, 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
